// File: rtl/btb_update_queue.sv
// btb_update_queue: classifies resolved branches into BTB write/invalidate ops, queues them in order and drains up to two per cycle into the BTB.
// Ports: clk, rst_n (async, active-low); res_* lanes a/b (a older) from execute;
// res_ready (>=2 free entries, registered), dropped (per-lane op discarded while not ready);
// wr_en/orig_pc/target_pc BTB write port; invalidate/pc_invalid BTB invalidate port; occupancy.
module btb_update_queue #(
  parameter int DEPTH    = 8,
  parameter int BTB_SIZE = 1024
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       res_valid_a,
  input  logic [31:0]                res_pc_a,
  input  logic [31:0]                res_target_a,
  input  logic                       res_taken_a,
  input  logic                       res_btb_hit_a,
  input  logic [31:0]                res_pred_target_a,
  input  logic                       res_valid_b,
  input  logic [31:0]                res_pc_b,
  input  logic [31:0]                res_target_b,
  input  logic                       res_taken_b,
  input  logic                       res_btb_hit_b,
  input  logic [31:0]                res_pred_target_b,
  output logic                       res_ready,
  output logic [1:0]                 dropped,
  output logic                       wr_en,
  output logic [31:0]                orig_pc,
  output logic [31:0]                target_pc,
  output logic                       invalidate,
  output logic [31:0]                pc_invalid,
  output logic [$clog2(DEPTH):0]     occupancy
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SB = $clog2(BTB_SIZE);
  logic          op_q [DEPTH];
  logic          op_d [DEPTH];
  logic [31:0]   pc_q [DEPTH];
  logic [31:0]   pc_d [DEPTH];
  logic [31:0]   tg_q [DEPTH];
  logic [31:0]   tg_d [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d, wb, hd, nx;
  logic [CW-1:0] occ_q, occ_d;
  logic          rdy_q, rdy_d;
  logic          wa, ia, wb_op, ib, push_a, push_b, hv, nv, pair;
  logic [1:0]    pops;
  always_comb begin
    wa     = res_valid_a & res_taken_a & !(res_btb_hit_a & (res_pred_target_a == res_target_a));
    ia     = res_valid_a & !res_taken_a & res_btb_hit_a;
    wb_op  = res_valid_b & res_taken_b & !(res_btb_hit_b & (res_pred_target_b == res_target_b));
    ib     = res_valid_b & !res_taken_b & res_btb_hit_b;
    push_a = rdy_q & (wa | ia);
    push_b = rdy_q & (wb_op | ib);
    dropped = {(wb_op | ib) & !rdy_q, (wa | ia) & !rdy_q};
    wb     = wr_q + PW'(push_a);
    op_d   = op_q;
    pc_d   = pc_q;
    tg_d   = tg_q;
    if (push_a) begin
      op_d[wr_q] = wa;
      pc_d[wr_q] = res_pc_a;
      tg_d[wr_q] = res_target_a;
    end
    if (push_b) begin
      op_d[wb] = wb_op;
      pc_d[wb] = res_pc_b;
      tg_d[wb] = res_target_b;
    end
    hd   = rd_q;
    nx   = rd_q + PW'(1);
    hv   = occ_q != '0;
    nv   = occ_q >= CW'(2);
    // an INV followed by a WRITE to the same line must serialize, or the invalidate would mask the write
    pair = nv & (op_q[hd] ? !op_q[nx] : op_q[nx] & (pc_q[nx][SB+1:2] != pc_q[hd][SB+1:2]));
    wr_en      = hv & (op_q[hd] | pair);
    invalidate = hv & (!op_q[hd] | pair);
    orig_pc    = !wr_en ? '0 : op_q[hd] ? pc_q[hd] : pc_q[nx];
    target_pc  = !wr_en ? '0 : op_q[hd] ? tg_q[hd] : tg_q[nx];
    pc_invalid = !invalidate ? '0 : !op_q[hd] ? pc_q[hd] : pc_q[nx];
    pops  = pair ? 2'd2 : {1'b0, hv};
    wr_d  = wr_q + PW'(push_a) + PW'(push_b);
    rd_d  = rd_q + PW'(pops);
    occ_d = occ_q + CW'(push_a) + CW'(push_b) - CW'(pops);
    rdy_d = (CW'(DEPTH) - occ_d) >= CW'(2);
    occupancy = occ_q;
    res_ready = rdy_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      occ_q <= '0;
      rdy_q <= 1'b1;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      occ_q <= occ_d;
      rdy_q <= rdy_d;
    end
  end
  always_ff @(posedge clk) begin
    op_q <= op_d;
    pc_q <= pc_d;
    tg_q <= tg_d;
  end
endmodule

// File: tb/tb_btb_update_queue.sv
// tb_btb_update_queue: directed vector table plus hand sequences for pairing, fill/drop and reset-mid-drain of btb_update_queue.
module tb_btb_update_queue;
  localparam logic T = 1'b1;
  localparam logic F = 1'b0;
  typedef struct packed {
    logic va, tka, hita;
    logic [31:0] pca, tga, pta;
    logic vb, tkb, hitb;
    logic [31:0] pcb, tgb, ptb;
    logic wr, inv;
    logic [31:0] opc, tpc, pinv;
    logic [3:0] o1, o2;
  } vec_t;
  logic clk = 0, rst_n = 0;
  logic res_valid_a, res_taken_a, res_btb_hit_a, res_valid_b, res_taken_b, res_btb_hit_b;
  logic [31:0] res_pc_a, res_target_a, res_pred_target_a, res_pc_b, res_target_b, res_pred_target_b;
  logic res_ready, wr_en, invalidate;
  logic [1:0] dropped;
  logic [31:0] orig_pc, target_pc, pc_invalid;
  logic [3:0] occupancy;
  int tests = 0, fails = 0, mi = 0;
  logic mon_en = 0;
  logic [31:0] fexp [12];
  vec_t vecs [11];
  vec_t z = '0;
  logic prv_v = 0, prv_rdy = 0;
  logic [3:0] prv_occ = 0;
  always #5 clk = ~clk;
  btb_update_queue dut (
    .clk(clk), .rst_n(rst_n),
    .res_valid_a(res_valid_a), .res_pc_a(res_pc_a), .res_target_a(res_target_a),
    .res_taken_a(res_taken_a), .res_btb_hit_a(res_btb_hit_a), .res_pred_target_a(res_pred_target_a),
    .res_valid_b(res_valid_b), .res_pc_b(res_pc_b), .res_target_b(res_target_b),
    .res_taken_b(res_taken_b), .res_btb_hit_b(res_btb_hit_b), .res_pred_target_b(res_pred_target_b),
    .res_ready(res_ready), .dropped(dropped), .wr_en(wr_en), .orig_pc(orig_pc),
    .target_pc(target_pc), .invalidate(invalidate), .pc_invalid(pc_invalid), .occupancy(occupancy)
  );
  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endtask
  task automatic drive(input vec_t v);
    res_valid_a = v.va; res_taken_a = v.tka; res_btb_hit_a = v.hita;
    res_pc_a = v.pca; res_target_a = v.tga; res_pred_target_a = v.pta;
    res_valid_b = v.vb; res_taken_b = v.tkb; res_btb_hit_b = v.hitb;
    res_pc_b = v.pcb; res_target_b = v.tgb; res_pred_target_b = v.ptb;
  endtask
  function automatic vec_t wpair(input logic [31:0] pa, input logic [31:0] pb);
    vec_t v = '0;
    v.va = T; v.tka = T; v.pca = pa; v.tga = pa + 32'h100;
    v.vb = T; v.tkb = T; v.pcb = pb; v.tgb = pb + 32'h100;
    return v;
  endfunction
  // a cycle in which the queue refuses input must never see occupancy grow
  always @(negedge clk) begin
    if (rst_n && prv_v && !prv_rdy)
      assert (occupancy <= prv_occ) else begin
        fails++;
        $display("FAIL overflow: got occupancy %0d want <= %0d", occupancy, prv_occ);
      end
    assert (occupancy <= 4'd8) else begin
      fails++;
      $display("FAIL occ_range: got %0d want <= 8", occupancy);
    end
    prv_v <= rst_n; prv_rdy <= res_ready; prv_occ <= occupancy;
  end
  always @(negedge clk) begin
    if (mon_en) begin
      chk("drain_inv", invalidate, F);
      if (wr_en) begin
        chk($sformatf("drain_pc%0d", mi), orig_pc, mi < 12 ? fexp[mi] : 32'hdead_beef);
        chk($sformatf("drain_tg%0d", mi), target_pc, mi < 12 ? fexp[mi] + 32'h100 : 32'hdead_beef);
        mi++;
      end
    end
  end
  initial begin
    vecs[0]  = '{T,T,F,32'h100,32'h200,0, F,F,F,0,0,0, T,F,32'h100,32'h200,0, 4'd1,4'd0};
    vecs[1]  = '{T,T,F,32'h100,32'h200,0, T,F,T,32'h340,0,0, T,T,32'h100,32'h200,32'h340, 4'd2,4'd0};
    vecs[2]  = '{T,F,T,32'h100,0,0, T,T,F,32'h1100,32'h80,0, F,T,0,0,32'h100, 4'd2,4'd1};
    vecs[3]  = '{T,F,T,32'h200,0,0, T,T,F,32'h204,32'h300,0, T,T,32'h204,32'h300,32'h200, 4'd2,4'd0};
    vecs[4]  = '{T,T,F,32'h100,32'h200,0, T,T,F,32'h104,32'h208,0, T,F,32'h100,32'h200,0, 4'd2,4'd1};
    vecs[5]  = '{T,F,T,32'h100,0,0, T,F,T,32'h104,0,0, F,T,0,0,32'h100, 4'd2,4'd1};
    vecs[6]  = '{T,T,T,32'h100,32'h400,32'h400, T,F,F,32'h104,32'h500,0, F,F,0,0,0, 4'd0,4'd0};
    vecs[7]  = '{T,T,T,32'h100,32'h400,32'h500, F,F,F,0,0,0, T,F,32'h100,32'h400,0, 4'd1,4'd0};
    vecs[8]  = '{F,F,F,0,0,0, T,T,F,32'h800,32'h900,0, T,F,32'h800,32'h900,0, 4'd1,4'd0};
    vecs[9]  = '{F,T,F,32'h100,32'h200,0, F,F,T,32'h104,0,0, F,F,0,0,0, 4'd0,4'd0};
    vecs[10] = '{T,F,T,32'h100,0,0, F,F,F,0,0,0, F,T,0,0,32'h100, 4'd1,4'd0};
    for (int k = 0; k < 6; k++) begin
      fexp[2*k]   = 32'h1000 + 32'(16*k);
      fexp[2*k+1] = 32'h1004 + 32'(16*k);
    end
    drive(z);
    #12;
    chk("rst_state", {res_ready, dropped, wr_en, invalidate, occupancy, orig_pc, pc_invalid},
        {T, 2'b00, F, F, 4'd0, 32'h0, 32'h0});
    @(posedge clk); #1 rst_n = 1;
    for (int i = 0; i < 11; i++) begin
      @(posedge clk); #1 drive(vecs[i]);
      @(negedge clk) chk($sformatf("vec%0d_drop", i), dropped, 2'b00);
      @(posedge clk); #1 drive(z);
      @(negedge clk) chk($sformatf("vec%0d_out", i),
        {wr_en, invalidate, orig_pc, target_pc, pc_invalid, occupancy},
        {vecs[i].wr, vecs[i].inv, vecs[i].opc, vecs[i].tpc, vecs[i].pinv, vecs[i].o1});
      @(negedge clk) chk($sformatf("vec%0d_occ2", i), occupancy, vecs[i].o2);
      repeat (3) @(negedge clk);
    end
    // same-line INV then WRITE: second cycle issues the write alone
    @(posedge clk); #1 drive(vecs[2]);
    @(posedge clk); #1 drive(z);
    @(negedge clk) chk("sl_c1", {wr_en, invalidate, pc_invalid}, {F, T, 32'h100});
    @(negedge clk) chk("sl_c2", {wr_en, invalidate, orig_pc, target_pc, occupancy},
                       {T, F, 32'h1100, 32'h80, 4'd1});
    @(negedge clk) chk("sl_c3", {wr_en, occupancy}, {F, 4'd0});
    // fill: dual pushes while draining one per cycle, then a refused pair
    @(posedge clk); #1 mon_en = 1;
    for (int k = 0; k < 6; k++) begin
      drive(wpair(fexp[2*k], fexp[2*k+1]));
      @(negedge clk) chk($sformatf("fill%0d", k), {res_ready, dropped}, {T, 2'b00});
      @(posedge clk); #1;
    end
    drive(wpair(32'h2000, 32'h2004));
    @(negedge clk) chk("full", {res_ready, dropped, occupancy}, {F, 2'b11, 4'd7});
    @(posedge clk); #1 drive(z);
    @(negedge clk) chk("after_drop", {res_ready, dropped, occupancy}, {T, 2'b00, 4'd6});
    repeat (12) @(negedge clk);
    chk("fill_drained", {mi[7:0], occupancy}, {8'd12, 4'd0});
    mon_en = 0;
    // reset with five entries pending
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1 drive(wpair(32'h3000 + 32'(16*k), 32'h3004 + 32'(16*k)));
    end
    @(posedge clk); #1 drive(z);
    @(negedge clk) chk("pre_rst", {wr_en, occupancy}, {T, 4'd5});
    #1 rst_n = 0;
    #1 chk("mid_rst", {wr_en, invalidate, orig_pc, target_pc, occupancy, res_ready},
           {F, F, 32'h0, 32'h0, 4'd0, T});
    @(posedge clk); #1 rst_n = 1;
    for (int k = 0; k < 6; k++)
      @(negedge clk) chk($sformatf("post_rst%0d", k), {wr_en, invalidate, occupancy, res_ready},
                         {F, F, 4'd0, T});
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/btb_update_queue.md
Name: btb_update_queue

Overview:
- Sits between branch resolution in execute and the dual-read branch target buffer (BTB).
- Accepts up to two resolved branches per cycle (lane a older than lane b). Classifies each as BTB WRITE, INVALIDATE, or no-op, and buffers the ops in order in a FIFO.
- Drains the FIFO into the BTB's single write port and single invalidate port, issuing up to two ops per cycle when ordering allows.
- BTB updates are hints: when the queue is short on space it drops them and reports the drop, with no backpressure on execute.

Parameters:
- DEPTH, 8, FIFO entries; power of two, at least 4.
- BTB_SIZE, 1024, BTB line count; SEL_BITS = $clog2(BTB_SIZE); line index = pc[SEL_BITS+1:2].

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- res_valid_a  in  1  lane a resolved branch valid
- res_pc_a  in  32  lane a branch PC
- res_target_a  in  32  lane a actual target
- res_taken_a  in  1  lane a actual direction
- res_btb_hit_a  in  1  lane a was fetched with a BTB hit
- res_pred_target_a  in  32  lane a BTB-predicted target; meaningful only when res_btb_hit_a=1
- res_valid_b / res_pc_b / res_target_b / res_taken_b / res_btb_hit_b / res_pred_target_b  in  1/32/32/1/1/32  lane b, same meanings
- res_ready  out  1  at least 2 entries free (registered)
- dropped  out  2  per-lane pulse: valid op discarded because res_ready=0
- wr_en  out  1  BTB write strobe
- orig_pc  out  32  BTB write PC
- target_pc  out  32  BTB write target
- invalidate  out  1  BTB invalidate strobe
- pc_invalid  out  32  BTB invalidate PC
- occupancy  out  $clog2(DEPTH)+1  entries held

Behaviour:
- Classification, per lane, when res_valid=1:
  - taken & !(btb_hit & pred_target==target) -> WRITE{pc, target}
  - !taken & btb_hit -> INVALIDATE{pc}
  - otherwise -> no-op; no entry is created and nothing is dropped.
- Enqueue:
  - Enqueue happens only if res_ready=1 in that cycle.
  - If both lanes produce ops, a is written at tail and b at tail+1.
  - If res_ready=0, each lane that produced an op pulses dropped[lane] for 1 cycle. Queue state is unchanged.
- Entry format: {op, pc[31:0], target[31:0]}. Read/write pointers are log2(DEPTH) bits wide and wrap modulo DEPTH.
- Drain:
  - Outputs are combinational from registered head entries only; there is no input-to-output path.
  - Strobes are 0 when the queue is empty.
  - Let H = head and N = head+1 (valid only if occupancy ≥2).
  - H=WRITE: wr_en=1 with H's fields. If N=INVALIDATE, also drive invalidate=1 with N's PC and pop 2. The BTB gives invalidate priority on a same-line conflict, which matches program order.
  - H=INVALIDATE: invalidate=1 with H's PC. If N=WRITE and line(N.pc)≠line(H.pc), also drive wr_en=1 with N and pop 2. On a same line, pop only 1 so the younger write is not masked.
  - Same-type pairs (WRITE,WRITE or INV,INV) always pop 1.
- Latency: an op enqueued at clock edge E drives the BTB strobes during the cycle after E at the earliest.
- Simultaneous push and pop: occupancy_next = occupancy + pushes - pops, in range 0..DEPTH.
- res_ready is registered: res_ready <= (DEPTH - occupancy_next) ≥ 2.
- Overflow is impossible by construction. An enqueue while res_ready=0 is a design bug, and the bench checks for it with an assertion.
- Reset, including mid-operation: pointers=0, occupancy=0, res_ready=1, dropped=0, wr_en=0, invalidate=0. orig_pc, target_pc and pc_invalid read 0 when the strobes are 0. FIFO data is not reset.

Test Plan:
- Single write: lane a pc=0x100, target=0x200, taken, no hit, at edge E -> the cycle after E has wr_en=1, orig_pc=0x100, target_pc=0x200, invalidate=0; occupancy back to 0.
- Pairing: in one cycle lane a WRITE(0x100→0x200) and lane b INV(0x340) -> the next cycle has wr_en and invalidate both asserted, pc_invalid=0x340, both popped in 1 cycle.
- Same-line serialization: lane a INV(0x100) then lane b WRITE(0x1100→0x80) (both line 0x040) -> cycle 1 invalidate only; cycle 2 wr_en only with orig_pc=0x1100.
- No-op filter: taken, hit, pred_target==target=0x400; also not-taken with no hit -> no entry, occupancy unchanged, dropped=0.
- Fill and drop: back-to-back dual WRITE pushes with distinct PCs, 6 accepted, then res_ready=0 -> 2 lanes pushed while res_ready=0 give dropped=2'b11; all accepted entries drain one per cycle in order with correct wrap.
- Reset mid-drain with occupancy 5 -> strobes deassert asynchronously; after release, occupancy=0, res_ready=1, and no stale writes are issued.
